// File: rtl/demod_qam_if.sv
// Stream bundle for demod_qam: {I,Q} symbol input with mode/flush, and the
// packed-word output handshake. The demodulator uses the slave modport.
interface demod_qam_if #(
    parameter int SAMPLE_W = 4,
    parameter int OUT_W    = 8
) ();
    logic [2*SAMPLE_W-1:0] i_data;
    logic                  i_enb;
    logic [1:0]            i_mode;
    logic                  i_flush;
    logic                  i_ready;
    logic                  o_ready;
    logic [OUT_W-1:0]      o_data;
    logic                  o_valid;

    modport master (
        output i_data, i_enb, i_mode, i_flush, i_ready,
        input  o_ready, o_data, o_valid
    );

    modport slave (
        input  i_data, i_enb, i_mode, i_flush, i_ready,
        output o_ready, o_data, o_valid
    );
endinterface

// File: rtl/demod_qam.sv
// Multi-mode (QPSK/QAM16/QAM64) hard-decision QAM slicer with Gray mapping and
// OUT_W-bit word packer. Define DEMOD_CLIP_CNT_EN to add the o_clip_cnt counter.
module demod_qam #(
    parameter int SAMPLE_W = 4,
    parameter int UNIT     = 1,
    parameter int OUT_W    = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
`ifdef DEMOD_CLIP_CNT_EN
    output logic [15:0] o_clip_cnt,
`endif
    demod_qam_if.slave  bus
);
    localparam int AW = OUT_W + 5;
    localparam int CW = $clog2(OUT_W + 6);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t                     state_q, state_d;
    logic                       s1_vld_q, s1_vld_d;
    logic                       s1_flush_q, s1_flush_d;
    logic [5:0]                 s1_bits_q, s1_bits_d;
    logic [2:0]                 s1_k_q, s1_k_d;
    logic [AW-1:0]              acc_q, acc_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [OUT_W-1:0]           o_data_q, o_data_d;
    logic                       o_valid_q, o_valid_d;

    logic                       advance;
    logic signed [SAMPLE_W-1:0] samp_i, samp_q;
    logic [1:0]                 lb;
    logic [2:0]                 gray_i, gray_q;
    logic [5:0]                 sym_bits;
    logic [2:0]                 sym_k;
    logic [AW-1:0]              acc_app;
    logic [CW-1:0]              cnt_app, rem;

    // Count of thresholds at or below x, then binary-to-Gray.
    function automatic logic [2:0] slice_axis(input logic signed [SAMPLE_W-1:0] x,
                                              input logic [1:0] lbits);
        int lv, xi, n;
        lv = 1 << lbits;
        xi = int'(x);
        n  = 0;
        for (int unsigned j = 0; j < 7; j++) begin
            if (int'(j) < lv - 1 && xi >= (2 * int'(j) - (lv - 2)) * UNIT) n++;
        end
        return 3'(n ^ (n >> 1));
    endfunction

    function automatic logic [OUT_W-1:0] pad_word(input logic [AW-1:0] a,
                                                  input logic [CW-1:0] c);
        return OUT_W'(a << (OUT_W - int'(c)));
    endfunction

    assign samp_i = bus.i_data[2*SAMPLE_W-1:SAMPLE_W];
    assign samp_q = bus.i_data[SAMPLE_W-1:0];

    always_comb begin
        unique case (bus.i_mode)
            2'd0:    lb = 2'd1;
            2'd2:    lb = 2'd3;
            default: lb = 2'd2;
        endcase
    end

    assign gray_i   = slice_axis(samp_i, lb);
    assign gray_q   = slice_axis(samp_q, lb);
    assign sym_bits = 6'((32'(gray_i) << lb) | 32'(gray_q));
    assign sym_k    = {lb, 1'b0};

    assign advance     = !o_valid_q || bus.i_ready;
    assign bus.o_ready = advance && (state_q == ST_RUN);
    assign bus.o_data  = o_data_q;
    assign bus.o_valid = o_valid_q;

    // Stage 1 is consumed by stage 2 exactly when o_ready is high, so it reloads then.
    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_flush_d = s1_flush_q;
        s1_bits_d  = s1_bits_q;
        s1_k_d     = s1_k_q;
        if (bus.o_ready) begin
            s1_vld_d   = bus.i_enb;
            s1_flush_d = bus.i_flush;
            s1_bits_d  = sym_bits;
            s1_k_d     = sym_k;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        acc_app   = acc_q;
        cnt_app   = cnt_q;
        if (s1_vld_q) begin
            acc_app = (acc_q << s1_k_q) | AW'(s1_bits_q);
            cnt_app = cnt_q + CW'(s1_k_q);
        end
        rem = cnt_app - CW'(OUT_W);
        if (advance) begin
            o_valid_d = 1'b0;
            if (state_q == ST_FLUSH) begin
                // Stage 1 is held this cycle; only the flushed residue leaves.
                o_data_d  = pad_word(acc_q, cnt_q);
                o_valid_d = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
                state_d   = ST_RUN;
            end else if (cnt_app >= CW'(OUT_W)) begin
                o_data_d  = OUT_W'(acc_app >> rem);
                o_valid_d = 1'b1;
                acc_d     = acc_app & ((AW'(1) << rem) - AW'(1));
                cnt_d     = rem;
                if (s1_flush_q && rem != '0) state_d = ST_FLUSH;
            end else if (s1_flush_q && cnt_app != '0) begin
                o_data_d  = pad_word(acc_app, cnt_app);
                o_valid_d = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
            end else begin
                acc_d = acc_app;
                cnt_d = cnt_app;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s1_vld_q   <= 1'b0;
            s1_flush_q <= 1'b0;
            s1_bits_q  <= '0;
            s1_k_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            o_data_q   <= '0;
            o_valid_q  <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_flush_q <= s1_flush_d;
            s1_bits_q  <= s1_bits_d;
            s1_k_q     <= s1_k_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            o_data_q   <= o_data_d;
            o_valid_q  <= o_valid_d;
        end
    end

`ifdef DEMOD_CLIP_CNT_EN
    logic        accept;
    logic [15:0] clip_q, clip_d;

    function automatic logic clips(input logic signed [SAMPLE_W-1:0] x,
                                   input logic [1:0] lbits);
        int xi;
        xi = int'(x);
        if (xi < 0) xi = -xi;
        return xi > ((1 << lbits) * UNIT);
    endfunction

    assign accept = bus.o_ready && bus.i_enb;

    always_comb begin
        clip_d = clip_q;
        if (accept && (clips(samp_i, lb) || clips(samp_q, lb)) && clip_q != '1)
            clip_d = clip_q + 16'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            clip_q <= '0;
        end else begin
            clip_q <= clip_d;
        end
    end

    assign o_clip_cnt = clip_q;
`endif
endmodule

// File: tb/tb_demod_qam.sv
// Directed, table-driven bench for demod_qam: slicing/packing vectors plus
// latency, flush-pending, backpressure and reset sequences.
module tb_demod_qam;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [7:0]  got_q[$];

    typedef struct packed {
        logic [2:0]      nsym;
        logic [3:0][1:0] mode;
        logic [3:0][7:0] data;
        logic            flush;
        logic [1:0]      nw;
        logic [2:0][7:0] words;
    } vec_t;

    vec_t vecs[9];

    demod_qam_if #(.SAMPLE_W(4), .OUT_W(8)) bus ();

`ifdef DEMOD_CLIP_CNT_EN
    logic [15:0] clip_cnt;
`endif

    demod_qam #(.SAMPLE_W(4), .UNIT(1), .OUT_W(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
`ifdef DEMOD_CLIP_CNT_EN
        .o_clip_cnt (clip_cnt),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && bus.o_valid && bus.i_ready) got_q.push_back(bus.o_data);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 1000000", $time);
        $fatal(1);
    end

    function automatic vec_t mk(input logic [2:0] n,
                                input logic [1:0] m0, input logic [7:0] d0,
                                input logic [1:0] m1, input logic [7:0] d1,
                                input logic [1:0] m2, input logic [7:0] d2,
                                input logic [1:0] m3, input logic [7:0] d3,
                                input logic fl, input logic [1:0] nw,
                                input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
        vec_t r;
        r.nsym  = n;
        r.mode  = {m3, m2, m1, m0};
        r.data  = {d3, d2, d1, d0};
        r.flush = fl;
        r.nw    = nw;
        r.words = {w2, w1, w0};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the request until o_ready is seen, returns 1 time unit after the accepting edge.
    task automatic send(input logic en, input logic [1:0] m, input logic [7:0] d, input logic fl);
        int t;
        t = 0;
        bus.i_enb   = en;
        bus.i_mode  = m;
        bus.i_data  = d;
        bus.i_flush = fl;
        @(negedge clk);
        while (!bus.o_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        chk("accept", 32'(bus.o_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.i_enb   = 1'b0;
        bus.i_flush = 1'b0;
    endtask

    task automatic chk_words(input string nm, input logic [1:0] nw, input logic [2:0][7:0] w);
        chk({nm, " count"}, 32'(got_q.size()), 32'(nw));
        for (int i = 0; i < int'(nw); i++)
            chk($sformatf("%s word%0d", nm, i),
                (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(w[i]));
        got_q.delete();
    endtask

    initial begin
        bus.i_enb   = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_mode  = 2'd0;
        bus.i_data  = 8'h00;
        bus.i_ready = 1'b1;

        vecs[0] = mk(3'd2, 2'd1, 8'h3D, 2'd1, 8'hF1, 2'd0, 8'h00, 2'd0, 8'h00, 1'b0, 2'd1, 8'h87, 8'h00, 8'h00);
        vecs[1] = mk(3'd4, 2'd0, 8'h1F, 2'd0, 8'h1F, 2'd0, 8'h1F, 2'd0, 8'h1F, 1'b0, 2'd1, 8'hAA, 8'h00, 8'h00);
        vecs[2] = mk(3'd4, 2'd2, 8'h79, 2'd2, 8'h79, 2'd2, 8'h79, 2'd2, 8'h79, 1'b0, 2'd3, 8'h82, 8'h08, 8'h20);
        vecs[3] = mk(3'd1, 2'd1, 8'h3D, 2'd0, 8'h00, 2'd0, 8'h00, 2'd0, 8'h00, 1'b1, 2'd1, 8'h80, 8'h00, 8'h00);
        vecs[4] = mk(3'd3, 2'd2, 8'h79, 2'd2, 8'h79, 2'd2, 8'h79, 2'd0, 8'h00, 1'b1, 2'd3, 8'h82, 8'h08, 8'h00);
        vecs[5] = mk(3'd2, 2'd0, 8'h1F, 2'd2, 8'h79, 2'd0, 8'h00, 2'd0, 8'h00, 1'b0, 2'd1, 8'hA0, 8'h00, 8'h00);
        vecs[6] = mk(3'd2, 2'd1, 8'h0E, 2'd3, 8'h20, 2'd0, 8'h00, 2'd0, 8'h00, 1'b0, 2'd1, 8'hDB, 8'h00, 8'h00);
        vecs[7] = mk(3'd3, 2'd0, 8'h1F, 2'd0, 8'h1F, 2'd0, 8'h1F, 2'd0, 8'h00, 1'b1, 2'd1, 8'hA8, 8'h00, 8'h00);
        vecs[8] = mk(3'd2, 2'd2, 8'h0A, 2'd0, 8'h80, 2'd0, 8'h00, 2'd0, 8'h00, 1'b0, 2'd1, 8'hC5, 8'h00, 8'h00);

        cycles(3);
        chk("reset o_valid", 32'(bus.o_valid), 32'd0);
        chk("reset o_data", 32'(bus.o_data), 32'h00);
        rst_n = 1'b1;
        cycles(1);
        chk("reset o_ready", 32'(bus.o_ready), 32'd1);

        // Latency: word visible 2 clocks after the completing symbol is accepted.
        send(1'b1, 2'd1, 8'h3D, 1'b0);
        send(1'b1, 2'd1, 8'hF1, 1'b0);
        chk("latency +1 o_valid", 32'(bus.o_valid), 32'd0);
        cycles(1);
        chk("latency +2 o_valid", 32'(bus.o_valid), 32'd1);
        chk("latency +2 o_data", 32'(bus.o_data), 32'h87);
        cycles(2);
        got_q.delete();

        // QPSK: nothing after 3 symbols, word after the 4th.
        for (int i = 0; i < 3; i++) send(1'b1, 2'd0, 8'h1F, 1'b0);
        cycles(5);
        chk_words("qpsk partial", 2'd0, '0);
        send(1'b1, 2'd0, 8'h1F, 1'b0);
        cycles(4);
        chk_words("qpsk full", 2'd1, {8'h00, 8'h00, 8'hAA});

        // Flush-only request, then flush with residue left after a full word.
        send(1'b1, 2'd1, 8'h3D, 1'b0);
        send(1'b0, 2'd0, 8'h00, 1'b1);
        cycles(4);
        chk_words("flush partial", 2'd1, {8'h00, 8'h00, 8'h80});
        send(1'b1, 2'd2, 8'h79, 1'b0);
        send(1'b1, 2'd2, 8'h79, 1'b0);
        send(1'b1, 2'd2, 8'h79, 1'b1);
        cycles(1);
        chk("pending o_ready", 32'(bus.o_ready), 32'd0);
        chk("pending o_data", 32'(bus.o_data), 32'h08);
        cycles(4);
        chk("after pending o_ready", 32'(bus.o_ready), 32'd1);
        chk_words("flush residue", 2'd3, {8'h00, 8'h08, 8'h82});

        for (int v = 0; v < 9; v++) begin
            for (int s = 0; s < int'(vecs[v].nsym); s++)
                send(1'b1, vecs[v].mode[s], vecs[v].data[s],
                     vecs[v].flush && (s == int'(vecs[v].nsym) - 1));
            cycles(6);
            chk_words($sformatf("vec%0d", v), vecs[v].nw, vecs[v].words);
        end

        // Backpressure: output held, input stalled, nothing lost.
        bus.i_ready = 1'b0;
        fork
            begin
                send(1'b1, 2'd1, 8'h3D, 1'b0);
                send(1'b1, 2'd1, 8'hF1, 1'b0);
                send(1'b1, 2'd1, 8'hF1, 1'b0);
                send(1'b1, 2'd1, 8'h3D, 1'b0);
                send(1'b1, 2'd1, 8'h0E, 1'b0);
                send(1'b1, 2'd1, 8'h20, 1'b0);
            end
            begin
                cycles(10);
                chk("bp o_valid", 32'(bus.o_valid), 32'd1);
                chk("bp o_data", 32'(bus.o_data), 32'h87);
                chk("bp o_ready", 32'(bus.o_ready), 32'd0);
                cycles(3);
                chk("bp o_data held", 32'(bus.o_data), 32'h87);
                bus.i_ready = 1'b1;
            end
        join
        cycles(6);
        chk_words("bp words", 2'd3, {8'hDB, 8'h78, 8'h87});

        // Reset mid-word discards the partial nibble.
        send(1'b1, 2'd1, 8'h3D, 1'b0);
        cycles(2);
        rst_n = 1'b0;
        #2;
        chk("midreset o_valid", 32'(bus.o_valid), 32'd0);
        cycles(1);
        rst_n = 1'b1;
        send(1'b1, 2'd1, 8'hF1, 1'b0);
        cycles(5);
        chk_words("midreset partial", 2'd0, '0);
        send(1'b1, 2'd1, 8'h3D, 1'b0);
        cycles(5);
        chk_words("midreset fresh", 2'd1, {8'h00, 8'h00, 8'h78});

`ifdef DEMOD_CLIP_CNT_EN
        chk("clip start", 32'(clip_cnt), 32'd0);
        send(1'b1, 2'd1, 8'h81, 1'b0);
        cycles(1);
        chk("clip qam16 -8", 32'(clip_cnt), 32'd1);
        send(1'b1, 2'd2, 8'h79, 1'b0);
        cycles(1);
        chk("clip qam64 7", 32'(clip_cnt), 32'd1);
        send(1'b0, 2'd0, 8'h00, 1'b1);
        cycles(5);
        got_q.delete();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
